// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI arbiter slice
package spi_pkg;

   localparam int PKT_W         = 16;
   localparam int TO_CYCLES_DEF = 1023;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_ACK     = 3'd4
   } state_e;

   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and SPI master signals around the arbiter
interface spi_arbiter_if #(parameter int NUM_REQ = 4);
   import spi_pkg::*;

   localparam int ID_W = id_w(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [PKT_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]       req_width8;
   logic [NUM_REQ-1:0]       req_pos_edge;
   logic [NUM_REQ-1:0]       ack;
   logic                     err;
   logic                     busy;
   logic [ID_W-1:0]          grant_id;
   logic                     spi_wrt;
   logic [PKT_W-1:0]         spi_data;
   logic                     spi_width8;
   logic                     spi_pos_edge;
   logic                     spi_done;
   logic                     spi_ss_n;
   logic [NUM_REQ-1:0]       ss_n_out;

   modport slave (
      input  req, req_data, req_width8, req_pos_edge, spi_done, spi_ss_n,
      output ack, err, busy, grant_id, spi_wrt, spi_data, spi_width8, spi_pos_edge, ss_n_out
   );

   modport master (
      output req, req_data, req_width8, req_pos_edge, spi_done, spi_ss_n,
      input  ack, err, busy, grant_id, spi_wrt, spi_data, spi_width8, spi_pos_edge, ss_n_out
   );

endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// rtl/spi_arbiter_rr_pick.sv - combinational round-robin select, first set req at or after ptr
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);

   function automatic logic [W-1:0] wrap_add(input logic [W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return W'(s);
   endfunction

   // Walk offsets from far to near so the nearest set request is the last write.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            idx   = wrap_add(ptr, k);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sequencer sharing one SPI master among NUM_REQ requesters
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_arbiter_if.slave  bus
);

   localparam int ID_W  = id_w(NUM_REQ);
   localparam int CNT_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TO_CYCLES);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [PKT_W-1:0]   data_q, data_d;
   logic               w8_q, w8_d;
   logic               pe_q, pe_d;
   logic               to_q, to_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [ID_W-1:0]    pick_idx;
   logic               pick_valid;

   rr_pick #(.N(NUM_REQ), .W(ID_W)) u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         w8_q    <= 1'b0;
         pe_q    <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         w8_q    <= w8_d;
         pe_q    <= pe_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      w8_d    = w8_q;
      pe_d    = pe_q;
      to_d    = to_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (pick_valid) begin
               grant_d = pick_idx;
               data_d  = bus.req_data[int'(pick_idx)*PKT_W +: PKT_W];
               w8_d    = bus.req_width8[pick_idx];
               pe_d    = bus.req_pos_edge[pick_idx];
               to_d    = 1'b0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_WAIT_LO;
         end
         // Done is still high from idle here; only a low level proves the master started.
         ST_WAIT_LO: begin
            cnt_d = cnt_q + 1'b1;
            if (!bus.spi_done) begin
               state_d = ST_WAIT_HI;
            end else if (TO_CYCLES != 0 && cnt_q == TO_LIM) begin
               to_d    = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_WAIT_HI: begin
            if (bus.spi_done) state_d = ST_ACK;
         end
         ST_ACK: begin
            ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.spi_wrt      = (state_q == ST_ISSUE);
      bus.busy         = (state_q != ST_IDLE);
      bus.err          = (state_q == ST_ACK) && to_q;
      bus.ack          = '0;
      if (state_q == ST_ACK) bus.ack[grant_q] = 1'b1;
      bus.grant_id     = grant_q;
      bus.spi_data     = data_q;
      bus.spi_width8   = w8_q;
      bus.spi_pos_edge = pe_q;
      bus.ss_n_out     = '1;
      bus.ss_n_out[grant_q] = bus.spi_ss_n;
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench with a transaction-level arbiter model and SPI master model
module tb_spi_arbiter;

   localparam int NR = 4;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   spi_arbiter_if #(.NUM_REQ(NR)) bus ();

   spi_arbiter #(.NUM_REQ(NR), .TO_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   // SPI master model: done low from wrt+2 for xfer_len cycles, unless hang
   int lo_start = -1;
   int lo_end = -2;
   int xfer_len = 3;
   bit hang = 0;

   // event logs
   int grant_log[$];
   int wrt_cnt = 0, ack_cnt = 0;
   int wrt_cyc = -1, ack_cyc = -1, err_cyc = -100, rise_cyc = -1;
   bit prev_done = 1;
   bit auto_drop = 0;
   logic [NR-1:0] drop, last_ack, ss_seen;
   logic [15:0] wrt_data;
   bit w8_and, pe_and;

   // arbiter model: timestamps of the expected wrt and ack for the current grant
   bit m_busy, m_err, m_seen_lo, m_w8, m_pe;
   int m_gid, m_ptr, m_wrt_cyc, m_ack_cyc;
   logic [15:0] m_data;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_seen_lo = 0; m_w8 = 0; m_pe = 0;
      m_gid = 0; m_ptr = 0; m_wrt_cyc = -1; m_ack_cyc = -1; m_data = '0;
   endtask

   task automatic model_advance();
      if (!m_busy) begin
         if (|bus.req) begin
            int g = -1;
            for (int k = 0; k < NR; k++) begin
               int j = (m_ptr + k) % NR;
               if (g < 0 && bus.req[j]) g = j;
            end
            m_gid = g;
            m_data = bus.req_data[16*g +: 16];
            m_w8 = bus.req_width8[g];
            m_pe = bus.req_pos_edge[g];
            m_busy = 1; m_err = 0; m_seen_lo = 0;
            m_wrt_cyc = cyc + 1; m_ack_cyc = -1;
         end
      end else if (cyc == m_ack_cyc) begin
         m_busy = 0;
         m_ptr = (m_gid + 1) % NR;
      end else if (cyc > m_wrt_cyc && m_ack_cyc < 0) begin
         if (!bus.spi_done) m_seen_lo = 1;
         else if (m_seen_lo) m_ack_cyc = cyc + 1;
         else if (cyc == m_wrt_cyc + TO) begin
            m_ack_cyc = cyc + 1;
            m_err = 1;
         end
      end
   endtask

   task automatic compare();
      logic [NR-1:0] e_ack, e_ss;
      bit in_ack;
      in_ack = m_busy && (cyc == m_ack_cyc);
      e_ack = '0;
      if (in_ack) e_ack[m_gid] = 1'b1;
      e_ss = '1;
      e_ss[m_gid] = bus.spi_ss_n;
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("spi_wrt", int'(bus.spi_wrt), int'(m_busy && cyc == m_wrt_cyc));
      chk("ack", int'(bus.ack), int'(e_ack));
      chk("err", int'(bus.err), int'(in_ack && m_err));
      chk("grant_id", int'(bus.grant_id), m_gid);
      chk("spi_data", int'(bus.spi_data), int'(m_data));
      chk("spi_width8", int'(bus.spi_width8), int'(m_w8));
      chk("spi_pos_edge", int'(bus.spi_pos_edge), int'(m_pe));
      chk("ss_n_out", int'(bus.ss_n_out), int'(e_ss));
   endtask

   // one clock cycle, entered and left at the falling edge
   task automatic step();
      bus.spi_done = !(cyc >= lo_start && cyc <= lo_end);
      bus.spi_ss_n = bus.spi_done;
      #1;
      compare();
      if (bus.spi_done && !prev_done) rise_cyc = cyc;
      prev_done = bus.spi_done;
      if (!bus.spi_ss_n) ss_seen = bus.ss_n_out;
      if (bus.busy) begin
         w8_and = w8_and & bus.spi_width8;
         pe_and = pe_and & bus.spi_pos_edge;
      end
      if (bus.spi_wrt) begin
         grant_log.push_back(int'(bus.grant_id));
         wrt_cnt++;
         wrt_cyc = cyc;
         wrt_data = bus.spi_data;
         if (!hang) begin
            lo_start = cyc + 2;
            lo_end = cyc + 1 + xfer_len;
         end
      end
      if (|bus.ack) begin
         ack_cnt++;
         ack_cyc = cyc;
         last_ack = bus.ack;
      end
      if (bus.err) err_cyc = cyc;
      drop = auto_drop ? bus.ack : '0;
      model_advance();
      @(negedge clk);
      cyc++;
      bus.req = bus.req & ~drop;
   endtask

   task automatic run_until(input string nm, input int n, input int budget);
      int target = ack_cnt + n;
      int k = 0;
      while (ack_cnt < target && k < budget) begin
         step();
         k++;
      end
      chk(nm, int'(ack_cnt >= target), 1);
   endtask

   task automatic wait_wrt(input string nm, input int budget);
      int w0 = wrt_cnt;
      int k = 0;
      while (wrt_cnt == w0 && k < budget) begin
         step();
         k++;
      end
      chk(nm, int'(wrt_cnt > w0), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      lo_start = -1; lo_end = -2;
      bus.spi_done = 1'b1;
      bus.spi_ss_n = 1'b1;
      prev_done = 1;
      model_reset();
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_spi_wrt", int'(bus.spi_wrt), 0);
      chk("rst_ack", int'(bus.ack), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_grant_id", int'(bus.grant_id), 0);
      chk("rst_spi_data", int'(bus.spi_data), 0);
      chk("rst_ss_n_out", int'(bus.ss_n_out), 'hF);
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int c0;
      rst_n = 1'b0;
      bus.req = '0;
      bus.req_data = '0;
      bus.req_width8 = '0;
      bus.req_pos_edge = '0;
      bus.spi_done = 1'b1;
      bus.spi_ss_n = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();

      // all requesters held: rotation from ptr=0
      auto_drop = 0; xfer_len = 3;
      grant_log.delete();
      bus.req = 4'b1111;
      run_until("t2_run", 5, 200);
      bus.req = '0;
      chk("t2_wrt_count", grant_log.size(), 5);
      for (int k = 0; k < 5; k++) chk("t2_order", grant_log[k], exp_order[k]);
      step(); step();

      // single requester 2
      auto_drop = 1;
      ss_seen = '1;
      bus.req_data[47:32] = 16'hA5C3;
      bus.req_width8[2] = 1'b0;
      c0 = cyc;
      bus.req = 4'b0100;
      run_until("t1_run", 1, 100);
      chk("t1_wrt_latency", wrt_cyc - c0, 1);
      chk("t1_spi_data", int'(wrt_data), 'hA5C3);
      chk("t1_ss_n_out", int'(ss_seen), 'b1011);
      chk("t1_ack", int'(last_ack), 'b0100);
      chk("t1_ack_latency", ack_cyc - rise_cyc, 1);
      step();

      // width8/pos_edge latched and immune to later input changes
      bus.req_width8[0] = 1'b1;
      bus.req_pos_edge[0] = 1'b1;
      bus.req_data[15:0] = 16'h3C00;
      w8_and = 1; pe_and = 1;
      bus.req = 4'b0001;
      wait_wrt("t6_wrt", 20);
      bus.req_width8 = '0;
      bus.req_pos_edge = '0;
      bus.req_data[15:0] = 16'h1234;
      run_until("t6_run", 1, 100);
      chk("t6_width8", int'(w8_and), 1);
      chk("t6_pos_edge", int'(pe_and), 1);
      step();

      // requester 1 withdraws while its transfer is in flight
      xfer_len = 4;
      grant_log.delete();
      bus.req = 4'b0011;
      wait_wrt("t3_wrt", 20);
      chk("t3_first_grant", grant_log[0], 1);
      step(); step();
      bus.req[1] = 1'b0;
      run_until("t3_run", 1, 100);
      chk("t3_ack", int'(last_ack), 'b0010);
      run_until("t3_run2", 1, 100);
      chk("t3_next_grant", grant_log[grant_log.size()-1], 0);
      step();

      // master never starts: timeout
      hang = 1;
      err_cyc = -100;
      bus.req = 4'b0010;
      run_until("t4_run", 1, 60);
      chk("t4_err_latency", err_cyc - wrt_cyc, 16);
      chk("t4_ack", int'(last_ack), 'b0010);
      hang = 0;
      step(); step();
      chk("t4_idle", int'(bus.busy), 0);

      // reset in the middle of a transfer
      xfer_len = 6;
      grant_log.delete();
      bus.req = 4'b1100;
      wait_wrt("t5_wrt", 20);
      chk("t5_first_grant", grant_log[0], 2);
      step(); step();
      bus.req = 4'b1000;
      do_reset();
      run_until("t5_run", 1, 100);
      chk("t5_grant_after_reset", grant_log[grant_log.size()-1], 3);
      step();

      // randomized traffic
      auto_drop = 1;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
               bus.req[i] = 1'b1;
               bus.req_data[16*i +: 16] = 16'($urandom);
               bus.req_width8[i] = 1'($urandom);
               bus.req_pos_edge[i] = 1'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               bus.req_data[16*i +: 16] = 16'($urandom);
            end
         end
         xfer_len = $urandom_range(1, 5);
         hang = ($urandom_range(0, 19) == 0);
         step();
      end
      bus.req = '0;
      hang = 0;
      for (int n = 0; n < 40; n++) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
